alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Shares the single combinational ALU (4-bit function select into the 16-way result multiplexer, two WIDTH-bit operands) between NREQ requesters. It arbitrates round-robin, registers the winner's opcode and operands, drives them onto the ALU for one cycle, captures the result and returns it to the requester with a one-cycle valid pulse. A 16-bit op mask lets the system disable individual ALU functions; a masked request completes with an error response instead of executing.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request level
- req_op  in  4*NREQ  opcode for requester i in bits [4i+3:4i]
- req_a  in  WIDTH*NREQ  operand A for requester i
- req_b  in  WIDTH*NREQ  operand B for requester i
- op_mask  in  16  bit k = 1 means opcode k is enabled
- grant  out  NREQ  one-hot, one-cycle pulse: operands captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: response for requester i
- rsp_data  out  WIDTH  result; held until the next response
- rsp_err  out  1  qualifies rsp_valid: 1 = opcode was masked, rsp_data = 0
- alu_sel  out  4  ALU function select
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_result  in  WIDTH  combinational ALU output

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req is high, pick the winner round-robin starting at pointer ptr. Register opcode, A and B. Pulse grant[winner].
  - Opcode enabled in op_mask: go to EXEC.
  - Opcode masked: go to RESP with err pending and result 0.
  - No req: stay in IDLE.
- EXEC: alu_sel/alu_a/alu_b present the registered values. alu_result is sampled at the end of the cycle. Go to RESP.
- RESP: rsp_valid[winner]=1 for exactly this cycle, with rsp_data/rsp_err valid. Set ptr to (winner+1) mod NREQ. Go to IDLE.
- Requester protocol:
  - Hold req and operands stable until grant.
  - req may drop any time after grant. The in-flight op still completes and responds.
  - Re-raising req before rsp_valid is a new request, arbitrated only after RESP.
- Round-robin: ptr resets to 0. A sole requester is served repeatedly. No requester waits more than NREQ-1 other services.
- alu_sel/alu_a/alu_b hold their last registered values outside EXEC (no glitch-driven changes).
- op_mask is sampled only in IDLE at the arbitration edge. Later changes do not affect an in-flight op.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, grant=0, rsp_valid=0, rsp_err=0, rsp_data=0, alu_sel=0, alu_a=0, alu_b=0. Any in-flight op is discarded with no response.
- Enabled op: req sampled at edge N → grant high in cycle N+1 (EXEC) → rsp_valid high in cycle N+2 (RESP).
  - New arbitration at edge N+3.
  - Throughput is one op per 3 cycles.
- Masked op: grant in cycle N+1, which is also the RESP cycle, so rsp_valid is high in N+1 alongside grant.
  - Arbitration resumes at edge N+2.
- grant and rsp_valid are registered outputs and never high for more than one consecutive cycle.

## Structure
- Shared package alu_sched_pkg holds:
  - OP_W = 4 and NUM_OPS = 16 constants
  - state enum {IDLE, EXEC, RESP}
  - opcode constants matching the ALU mux input ordering
- Sub-module rr_arbiter: inputs req[NREQ] and ptr; output one-hot winner. Purely combinational, reusable by other shared units.

## Test plan
- Single requester: NREQ=4, req=0001, op=3, A=0x12, B=0x34, ALU model returns A+B.
  - grant=0001 one cycle after the sampling edge.
  - rsp_valid=0001 with rsp_data=0x46 one cycle later.
  - alu_sel=3 during EXEC.
- All requesters held high:
  - grants in order 0001, 0010, 0100, 1000, 0001.
  - each response carries its own requester's result.
  - 3-cycle spacing between grants.
- Masked op: op_mask=0xFFF7, req=0100 with op=3.
  - grant=0100 and rsp_valid=0100 in the same cycle, rsp_err=1, rsp_data=0.
  - alu_sel unchanged from its prior value.
- Reset during EXEC: rst_n=0 one cycle after grant.
  - no rsp_valid ever issued.
  - all outputs 0, next arbitration starts at requester 0.
- Req dropped after grant: req=0010 deasserted the cycle after grant.
  - rsp_valid=0010 still issued with the correct result.
- op_mask changed mid-op: op_mask cleared to 0x0000 during EXEC of op 5.
  - result still delivered with rsp_err=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the ALU operation scheduler and other units that
// share the combinational ALU.
//   OP_W     - width of the ALU function select
//   NUM_OPS  - number of ALU functions (one op_mask bit each)
//   state_e  - scheduler FSM states
//   alu_op_e - opcodes, in the order of the ALU result multiplexer inputs
// -----------------------------------------------------------------------------
package alu_sched_pkg;

  localparam int OP_W    = 4;
  localparam int NUM_OPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_NAND  = 4'd5,
    OP_NOR   = 4'd6,
    OP_XNOR  = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SRA   = 4'd10,
    OP_ROL   = 4'd11,
    OP_ROR   = 4'd12,
    OP_PASSA = 4'd13,
    OP_PASSB = 4'd14,
    OP_NOTA  = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler_if
// Bundles the requester side and the ALU side of the scheduler.
//   master modport : system view (drives requests, op mask and ALU result)
//   slave modport  : scheduler view
// Signals:
//   req/req_op/req_a/req_b - per-requester request level, opcode, operands
//   op_mask                - bit k enables opcode k
//   grant/rsp_valid        - one-hot single-cycle pulses per requester
//   rsp_data/rsp_err       - response payload, held until the next response
//   alu_sel/alu_a/alu_b    - registered drive of the shared ALU
//   alu_result             - combinational ALU output
// -----------------------------------------------------------------------------
interface alu_op_scheduler_if
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req;
  logic [OP_W*NREQ-1:0]  req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NUM_OPS-1:0]    op_mask;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic [OP_W-1:0]       alu_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_result;

  modport master (
    output req, req_op, req_a, req_b, op_mask, alu_result,
    input  grant, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

  modport slave (
    input  req, req_op, req_a, req_b, op_mask, alu_result,
    output grant, rsp_valid, rsp_data, rsp_err, alu_sel, alu_a, alu_b
  );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the lowest-numbered active request
// at or above ptr wins; if none, the lowest-numbered active request overall.
//   req    - request levels
//   ptr    - highest-priority requester index
//   winner - one-hot winner, all zero when no request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);

  logic [NREQ-1:0] at_or_above;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] pick_src;

  for (genvar i = 0; i < NREQ; i++) begin : g_mask
    assign at_or_above[i] = (PTR_W'(i) >= ptr);
  end

  assign req_hi   = req & at_or_above;
  assign pick_src = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit (x & -x).
  assign winner   = pick_src & (~pick_src + NREQ'(1));

endmodule

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
// Shares one combinational ALU between NREQ requesters. Round-robin picks a
// winner in IDLE, its operands are registered onto the ALU for one EXEC cycle,
// the result is captured and returned in RESP. Opcodes disabled in op_mask
// skip EXEC and answer with rsp_err=1, rsp_data=0.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_op_scheduler_if.slave (requests, responses, ALU drive)
// -----------------------------------------------------------------------------
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_idx_q, win_idx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [OP_W-1:0]   alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;

  logic [NREQ-1:0]             arb_oh;
  logic [PTR_W-1:0]            arb_idx;
  logic [PTR_W-1:0][NREQ-1:0]  enc_mask;
  logic [OP_W-1:0]             op_slot [NREQ];
  logic [WIDTH-1:0]            a_slot  [NREQ];
  logic [WIDTH-1:0]            b_slot  [NREQ];

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (arb_oh)
  );

  // Slice the flat request buses per requester and build the constant masks
  // used to encode the one-hot winner into an index.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign op_slot[i] = bus.req_op[i*OP_W +: OP_W];
    assign a_slot[i]  = bus.req_a[i*WIDTH +: WIDTH];
    assign b_slot[i]  = bus.req_b[i*WIDTH +: WIDTH];
    for (genvar j = 0; j < PTR_W; j++) begin : g_enc
      assign enc_mask[j][i] = ((i >> j) & 1) != 0;
    end
  end

  for (genvar j = 0; j < PTR_W; j++) begin : g_idx
    assign arb_idx[j] = |(arb_oh & enc_mask[j]);
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a signal
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_idx_d   = win_idx_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d   = arb_oh;
          win_idx_d = arb_idx;
          if (bus.op_mask[op_slot[arb_idx]]) begin
            // ALU drive only changes for ops that will execute, so a masked
            // op leaves the ALU inputs untouched.
            alu_sel_d = op_slot[arb_idx];
            alu_a_d   = a_slot[arb_idx];
            alu_b_d   = b_slot[arb_idx];
            state_d   = EXEC;
          end else begin
            // Masked: the grant cycle doubles as the response cycle.
            rsp_valid_d = arb_oh;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      EXEC: begin
        rsp_valid_d = grant_q;
        rsp_data_d  = bus.alu_result;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        ptr_d   = (win_idx_q == PTR_W'(NREQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_idx_q   <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_idx_q   <= win_idx_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_op_scheduler
// Directed bench for alu_op_scheduler (WIDTH=8, NREQ=4). Stimulus pushes the
// expected response into a queue; a monitor pops and compares on every
// rsp_valid pulse. Timing and ALU-drive checks are made inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  typedef struct packed {
    logic [NREQ-1:0]  who;
    logic [WIDTH-1:0] data;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rsp_t exp_q[$];
  rsp_t mon_e;

  logic [NREQ-1:0][3:0]       ops;
  logic [NREQ-1:0][WIDTH-1:0] as;
  logic [NREQ-1:0][WIDTH-1:0] bs;
  logic [NREQ-1:0]            prev_grant = '0;
  logic [NREQ-1:0]            prev_rv = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_op_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.req_op = ops;
  assign bus.req_a  = as;
  assign bus.req_b  = bs;

  function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] s,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (s)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return ~(a & b);
      default: return '0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input logic [1:0] s, input logic [3:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ops[s] = op;
    as[s]  = a;
    bs[s]  = b;
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] exp, output int at);
    int n = 0;
    @(negedge clk);
    while (bus.grant == '0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.grant), 32'(exp));
    at = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},     32'(bus.grant),     32'(0));
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(0));
    check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'(0));
    check({tag, "_alu_sel"},   32'(bus.alu_sel),   32'(0));
    check({tag, "_alu_a"},     32'(bus.alu_a),     32'(0));
    check({tag, "_alu_b"},     32'(bus.alu_b),     32'(0));
  endtask

  // Response monitor: scoreboard pop on every rsp_valid, plus pulse-width checks.
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_who",  32'(bus.rsp_valid), 32'(mon_e.who));
        check("rsp_data", 32'(bus.rsp_data),  32'(mon_e.data));
        check("rsp_err",  32'(bus.rsp_err),   32'(mon_e.err));
      end
      check("rsp_valid_pulse", 32'(prev_rv), 32'(0));
    end
    if (bus.grant != '0) check("grant_pulse", 32'(prev_grant), 32'(0));
    prev_grant <= bus.grant;
    prev_rv    <= bus.rsp_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int g;
    int prev_g;
    logic [NREQ-1:0] eg;

    bus.req     = '0;
    bus.op_mask = 16'hFFFF;
    ops = '0;
    as  = '0;
    bs  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester, ADD 0x12+0x34.
    @(posedge clk); #1;
    set_slot(2'd0, 4'd3, 8'h12, 8'h34);
    exp_q.push_back('{4'b0001, 8'h46, 1'b0});
    bus.req = 4'b0001;
    t0 = cyc;
    wait_grant("t1_grant", 4'b0001, g);
    check("t1_grant_lat", 32'(g), 32'(t0 + 1));
    check("t1_alu_sel", 32'(bus.alu_sel), 32'(3));
    check("t1_alu_a",   32'(bus.alu_a),   32'(8'h12));
    check("t1_alu_b",   32'(bus.alu_b),   32'(8'h34));
    bus.req = '0;
    @(negedge clk);
    check("t1_rsp_lat", 32'(bus.rsp_valid), 32'(4'b0001));

    // Requester 1, SUB 0x50-0x21, req dropped the cycle after grant.
    repeat (2) @(posedge clk); #1;
    set_slot(2'd1, 4'd4, 8'h50, 8'h21);
    exp_q.push_back('{4'b0010, 8'h2F, 1'b0});
    bus.req = 4'b0010;
    t0 = cyc;
    wait_grant("t2_grant", 4'b0010, g);
    check("t2_grant_lat", 32'(g), 32'(t0 + 1));
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    check("t2_rsp_lat", 32'(bus.rsp_valid), 32'(4'b0010));

    // Masked opcode 3 on requester 2.
    repeat (2) @(posedge clk); #1;
    bus.op_mask = 16'hFFF7;
    set_slot(2'd2, 4'd3, 8'h01, 8'h02);
    exp_q.push_back('{4'b0100, 8'h00, 1'b1});
    bus.req = 4'b0100;
    t0 = cyc;
    wait_grant("t3_grant", 4'b0100, g);
    check("t3_grant_lat",   32'(g), 32'(t0 + 1));
    check("t3_rsp_same",    32'(bus.rsp_valid), 32'(4'b0100));
    check("t3_alu_sel_kept", 32'(bus.alu_sel), 32'(4));
    check("t3_alu_a_kept",   32'(bus.alu_a),   32'(8'h50));
    check("t3_alu_b_kept",   32'(bus.alu_b),   32'(8'h21));
    bus.req = '0;
    bus.op_mask = 16'hFFFF;
    @(negedge clk);
    check("t3_rsp_end", 32'(bus.rsp_valid), 32'(0));

    // Op 5 on requester 3; op_mask cleared during EXEC must not matter.
    repeat (2) @(posedge clk); #1;
    set_slot(2'd3, 4'd5, 8'h0F, 8'hF0);
    exp_q.push_back('{4'b1000, 8'hFF, 1'b0});
    bus.req = 4'b1000;
    wait_grant("t4_grant", 4'b1000, g);
    check("t4_alu_sel", 32'(bus.alu_sel), 32'(5));
    bus.op_mask = 16'h0000;
    bus.req = '0;
    @(negedge clk);
    check("t4_rsp_lat", 32'(bus.rsp_valid), 32'(4'b1000));
    bus.op_mask = 16'hFFFF;

    // All requesters held: round-robin order with 3-cycle spacing.
    repeat (2) @(posedge clk); #1;
    set_slot(2'd0, 4'd0, 8'hF0, 8'h3C);
    set_slot(2'd1, 4'd1, 8'h0F, 8'h30);
    set_slot(2'd2, 4'd2, 8'hAA, 8'hFF);
    set_slot(2'd3, 4'd3, 8'h80, 8'h81);
    exp_q.push_back('{4'b0001, 8'h30, 1'b0});
    exp_q.push_back('{4'b0010, 8'h3F, 1'b0});
    exp_q.push_back('{4'b0100, 8'h55, 1'b0});
    exp_q.push_back('{4'b1000, 8'h01, 1'b0});
    exp_q.push_back('{4'b0001, 8'h30, 1'b0});
    bus.req = 4'b1111;
    t0 = cyc;
    prev_g = t0 - 2;
    eg = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t5_grant", eg, g);
      check("t5_spacing", 32'(g - prev_g), 32'((k == 0) ? 3 : 3));
      prev_g = g;
      eg = {eg[NREQ-2:0], eg[NREQ-1]};
    end
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset during EXEC: no response, then arbitration restarts at requester 0.
    repeat (2) @(posedge clk); #1;
    set_slot(2'd2, 4'd3, 8'h20, 8'h22);
    bus.req = 4'b0100;
    wait_grant("t6_grant", 4'b0100, g);
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_all_zero("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    set_slot(2'd0, 4'd3, 8'h12, 8'h34);
    exp_q.push_back('{4'b0001, 8'h46, 1'b0});
    bus.req = 4'b1001;
    wait_grant("t6_ptr_reset", 4'b0001, g);
    bus.req = '0;
    repeat (4) @(negedge clk);

    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
